// File: rtl/fios_sequencer_pkg.sv
// Shared types and constants for the FIOS Montgomery multiplier sequencer.
package fios_sequencer_pkg;

  localparam int WORD_W = 17;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    DRAIN,
    HOLD
  } seq_state_e;

endpackage

// File: rtl/fios_sequencer_if.sv
// Job, multiplier and result signals between the sequencer and its neighbours.
interface fios_sequencer_if #(
  parameter int s     = 8,
  parameter int PE_NB = 8
);
  import fios_sequencer_pkg::*;

  logic                      req_i;
  logic                      ack_o;
  logic [s*WORD_W-1:0]       a_i;
  logic [s*WORD_W-1:0]       b_i;
  logic [s*WORD_W-1:0]       p_i;
  logic [WORD_W-1:0]         p_prime_0_i;
  logic [WORD_W-1:0]         p_prime_0_o;
  logic                      mult_start_o;
  logic [PE_NB*WORD_W-1:0]   mult_a_o;
  logic                      a_shift_i;
  logic                      b_fetch_i;
  logic                      p_fetch_i;
  logic [WORD_W-1:0]         mult_b_o;
  logic [WORD_W-1:0]         mult_p_o;
  logic                      res_push_i;
  logic [WORD_W-1:0]         res_i;
  logic                      mult_done_i;
  logic                      res_valid_o;
  logic                      res_ready_i;
  logic [s*WORD_W-1:0]       res_o;
  logic                      busy_o;
  logic                      err_o;

  modport slave (
    input  req_i, a_i, b_i, p_i, p_prime_0_i, a_shift_i, b_fetch_i, p_fetch_i,
           res_push_i, res_i, mult_done_i, res_ready_i,
    output ack_o, p_prime_0_o, mult_start_o, mult_a_o, mult_b_o, mult_p_o,
           res_valid_o, res_o, busy_o, err_o
  );

  modport master (
    output req_i, a_i, b_i, p_i, p_prime_0_i, a_shift_i, b_fetch_i, p_fetch_i,
           res_push_i, res_i, mult_done_i, res_ready_i,
    input  ack_o, p_prime_0_o, mult_start_o, mult_a_o, mult_b_o, mult_p_o,
           res_valid_o, res_o, busy_o, err_o
  );

endinterface

// File: rtl/fios_word_selector.sv
// Picks one 17-bit word out of a packed vector; indices past the end read as zero.
module fios_word_selector
  import fios_sequencer_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 4
) (
  input  logic [N*WORD_W-1:0] vec_i,
  input  logic [IDX_W-1:0]    idx_i,
  output logic [WORD_W-1:0]   word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_i == IDX_W'(i)) word_o = vec_i[i*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/fios_sequencer.sv
// Sequences one FIOS multiplication job: latches operands, feeds word windows to
// the multiplier, collects result words and hands the result back.
//
// state | meaning
// IDLE  | waiting for req_i; accepting latches operands and clears indices
// START | one-cycle multiplier start pulse
// RUN   | multiplier active; strobes move windows, results collected, watchdog counts
// DRAIN | one cycle for a late result push, then result-count check
// HOLD  | result presented until res_ready_i
module fios_sequencer
  import fios_sequencer_pkg::*;
#(
  parameter int s       = 8,
  parameter int PE_NB   = 8,
  parameter int TIMEOUT = 4096
) (
  input logic             clock_i,
  input logic             reset_ni,
  fios_sequencer_if.slave bus
);

  localparam int IDX_W  = $clog2(s + 1);
  localparam int LANE_W = $clog2(s + PE_NB);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int VEC_W  = s * WORD_W;
  localparam logic [IDX_W-1:0] S_IDX    = IDX_W'(s);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(s - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  seq_state_e state_q, state_d;
  logic [VEC_W-1:0]  a_q, a_d, b_q, b_d, p_q, p_d, res_q, res_d;
  logic [WORD_W-1:0] pp0_q, pp0_d;
  logic [IDX_W-1:0]  k_q, k_d, jb_q, jb_d, jp_q, jp_d, r_q, r_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic err_q, err_d, start_q, start_d, busy_q, busy_d, valid_q, valid_d;
  logic accept, in_run, push_en;
  logic [IDX_W:0]    k_sum;
  logic [IDX_W-1:0]  k_sat;
  logic [PE_NB*WORD_W-1:0] a_win;

  assign accept  = (state_q == IDLE) && bus.req_i;
  assign in_run  = (state_q == RUN);
  assign push_en = (state_q == RUN) || (state_q == DRAIN);

  // PE_NB <= s, so the sum never wraps in IDX_W+1 bits.
  assign k_sum = {1'b0, k_q} + (IDX_W+1)'(PE_NB);
  assign k_sat = (k_sum >= {1'b0, S_IDX}) ? S_IDX : k_sum[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    pp0_d   = pp0_q;
    res_d   = res_q;
    k_d     = k_q;
    jb_d    = jb_q;
    jp_d    = jp_q;
    r_d     = r_q;
    wd_d    = wd_q;
    err_d   = err_q;

    if (in_run) begin
      if (bus.a_shift_i) k_d = k_sat;
      if (bus.b_fetch_i) jb_d = (jb_q == LAST_IDX) ? '0 : jb_q + 1'b1;
      if (bus.p_fetch_i) jp_d = (jp_q == LAST_IDX) ? '0 : jp_q + 1'b1;
    end

    if (push_en && bus.res_push_i) begin
      if (r_q == S_IDX) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < s; i++) begin
          if (r_q == IDX_W'(i)) res_d[i*WORD_W +: WORD_W] = bus.res_i;
        end
        r_d = r_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          state_d = START;
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          p_d     = bus.p_i;
          pp0_d   = bus.p_prime_0_i;
          res_d   = '0;
          k_d     = '0;
          jb_d    = '0;
          jp_d    = '0;
          r_d     = '0;
          wd_d    = '0;
          err_d   = 1'b0;
        end
      end
      START: state_d = RUN;
      RUN: begin
        wd_d = wd_q + 1'b1;
        // A completing multiplier wins over a watchdog expiring on the same cycle.
        if (bus.mult_done_i) begin
          state_d = DRAIN;
        end else if (wd_q == WD_LAST) begin
          state_d = HOLD;
          err_d   = 1'b1;
        end
      end
      DRAIN: begin
        state_d = HOLD;
        if (r_d != S_IDX) err_d = 1'b1;
      end
      HOLD: if (bus.res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      pp0_q   <= '0;
      res_q   <= '0;
      k_q     <= '0;
      jb_q    <= '0;
      jp_q    <= '0;
      r_q     <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      pp0_q   <= pp0_d;
      res_q   <= res_d;
      k_q     <= k_d;
      jb_q    <= jb_d;
      jp_q    <= jp_d;
      r_q     <= r_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  fios_word_selector #(.N(s), .IDX_W(IDX_W)) u_sel_b (
    .vec_i (b_q),
    .idx_i (jb_q),
    .word_o(bus.mult_b_o)
  );

  fios_word_selector #(.N(s), .IDX_W(IDX_W)) u_sel_p (
    .vec_i (p_q),
    .idx_i (jp_q),
    .word_o(bus.mult_p_o)
  );

  for (genvar g = 0; g < PE_NB; g++) begin : g_lane
    logic [LANE_W-1:0] lane_idx;
    assign lane_idx = LANE_W'(k_q) + LANE_W'(g);
    fios_word_selector #(.N(s), .IDX_W(LANE_W)) u_sel_a (
      .vec_i (a_q),
      .idx_i (lane_idx),
      .word_o(a_win[g*WORD_W +: WORD_W])
    );
  end

  // Ack is combinational so it lands in the accept cycle; gated so reset reads 0.
  assign bus.ack_o        = accept && reset_ni;
  assign bus.mult_start_o = start_q;
  assign bus.mult_a_o     = a_win;
  assign bus.p_prime_0_o  = pp0_q;
  assign bus.res_valid_o  = valid_q;
  assign bus.res_o        = res_q;
  assign bus.busy_o       = busy_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_fios_sequencer.sv
// Self-checking bench for fios_sequencer with s=8, PE_NB=4, TIMEOUT=64.
module tb_fios_sequencer;
  import fios_sequencer_pkg::*;

  localparam int S  = 8;
  localparam int PE = 4;
  localparam int TO = 64;
  localparam int RW = S * WORD_W;
  localparam int AW = PE * WORD_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [RW-1:0]     exp_q[$];
  logic [WORD_W-1:0] aw [S];
  logic [WORD_W-1:0] bw [S];
  logic [WORD_W-1:0] pw [S];
  logic [WORD_W-1:0] rw [S];

  typedef struct {
    logic              ash;
    logic              bf;
    logic              pf;
    int                k;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] p;
  } vec_t;
  vec_t vt [13];

  always #5 clk = ~clk;

  fios_sequencer_if #(.s(S), .PE_NB(PE)) bus ();

  fios_sequencer #(.s(S), .PE_NB(PE), .TIMEOUT(TO)) dut (
    .clock_i (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  function automatic logic [RW-1:0] pack(input logic [WORD_W-1:0] w [S]);
    logic [RW-1:0] v = '0;
    for (int i = 0; i < S; i++) v[i*WORD_W +: WORD_W] = w[i];
    return v;
  endfunction

  function automatic logic [AW-1:0] win(input int k);
    logic [AW-1:0] v = '0;
    for (int l = 0; l < PE; l++) if (k + l < S) v[l*WORD_W +: WORD_W] = aw[k+l];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, RW'(act), RW'(exp));
  endtask

  task automatic chkw(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    chk(nm, RW'(act), RW'(exp));
  endtask

  task automatic quiet_inputs();
    bus.req_i       = 1'b0;
    bus.a_shift_i   = 1'b0;
    bus.b_fetch_i   = 1'b0;
    bus.p_fetch_i   = 1'b0;
    bus.res_push_i  = 1'b0;
    bus.res_i       = '0;
    bus.mult_done_i = 1'b0;
    bus.res_ready_i = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ctl"}, RW'({bus.ack_o, bus.mult_start_o, bus.res_valid_o, bus.busy_o, bus.err_o}), '0);
    chk({nm, "_mult"}, RW'({bus.mult_a_o, bus.mult_b_o, bus.mult_p_o, bus.p_prime_0_o}), '0);
    chk({nm, "_res"}, bus.res_o, '0);
  endtask

  // Returns at the falling edge of the first RUN cycle.
  task automatic start_job(input logic [WORD_W-1:0] pp0);
    @(negedge clk);
    bus.req_i       = 1'b1;
    bus.a_i         = pack(aw);
    bus.b_i         = pack(bw);
    bus.p_i         = pack(pw);
    bus.p_prime_0_i = pp0;
    #1;
    chk1("ack_on_req", bus.ack_o, 1'b1);
    @(negedge clk);
    bus.req_i = 1'b0;
    #1;
    chk1("ack_pulse_end", bus.ack_o, 1'b0);
    chk1("mult_start", bus.mult_start_o, 1'b1);
    chk1("err_cleared", bus.err_o, 1'b0);
    chkw("p_prime_0", bus.p_prime_0_o, pp0);
    @(negedge clk);
    chk1("mult_start_one_cycle", bus.mult_start_o, 1'b0);
  endtask

  task automatic push(input logic [WORD_W-1:0] w, input logic done);
    bus.res_push_i  = 1'b1;
    bus.res_i       = w;
    bus.mult_done_i = done;
    @(negedge clk);
    bus.res_push_i  = 1'b0;
    bus.mult_done_i = 1'b0;
  endtask

  task automatic collect(input logic exp_err);
    int n = 0;
    logic [RW-1:0] e;
    while (!bus.res_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid_o) begin
      n_vec++;
      n_err++;
      $display("FAIL valid_timeout: res_valid_o still 0 after %0d cycles, want 1", n);
      return;
    end
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: result produced with no expectation queued");
      return;
    end
    e = exp_q.pop_front();
    chk("result", bus.res_o, e);
    chk1("err_at_hold", bus.err_o, exp_err);
    chk1("busy_in_hold", bus.busy_o, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk1("valid_held", bus.res_valid_o, 1'b1);
      chk("result_stable", bus.res_o, e);
    end
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
    chk1("valid_drop", bus.res_valid_o, 1'b0);
    chk1("busy_idle", bus.busy_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: run exceeded %0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int cnt;
    logic [RW-1:0] e;

    vt[0]  = '{1'b0, 1'b1, 1'b0, 0, 17'h201, 17'h300};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 0, 17'h202, 17'h300};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 0, 17'h203, 17'h300};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 0, 17'h204, 17'h300};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 0, 17'h205, 17'h300};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 0, 17'h206, 17'h300};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 0, 17'h207, 17'h300};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 0, 17'h200, 17'h300};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 0, 17'h201, 17'h300};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 0, 17'h202, 17'h301};
    vt[10] = '{1'b1, 1'b0, 1'b0, 4, 17'h202, 17'h301};
    vt[11] = '{1'b1, 1'b0, 1'b0, 8, 17'h202, 17'h301};
    vt[12] = '{1'b1, 1'b0, 1'b1, 8, 17'h202, 17'h302};

    quiet_inputs();
    bus.a_i = '0;
    bus.b_i = '0;
    bus.p_i = '0;
    bus.p_prime_0_i = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Job 1: a=1, b=3, p=0x10001; last push arrives with mult_done.
    for (int i = 0; i < S; i++) begin
      aw[i] = '0;
      bw[i] = '0;
      pw[i] = '0;
      rw[i] = 17'(i * 17'h2345 + 17'h11);
    end
    aw[0] = 17'h1;
    bw[0] = 17'h3;
    pw[0] = 17'h10001;
    start_job(17'h0FFFF);
    chk("a_window_k0", RW'(bus.mult_a_o), RW'(win(0)));
    chkw("b_word0", bus.mult_b_o, 17'h3);
    chkw("p_word0", bus.mult_p_o, 17'h10001);
    exp_q.push_back(pack(rw));
    for (int i = 0; i < S; i++) push(rw[i], (i == S - 1));
    collect(1'b0);

    // Job 2: table of window strobes, req ignored while busy, short result.
    for (int i = 0; i < S; i++) begin
      aw[i] = 17'(17'h100 + i);
      bw[i] = 17'(17'h200 + i);
      pw[i] = 17'(17'h300 + i);
      rw[i] = 17'(17'h1F000 - i * 17'h321);
    end
    start_job(17'h01234);
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
    chk1("ready_no_valid_busy", bus.busy_o, 1'b1);
    chk1("ready_no_valid_valid", bus.res_valid_o, 1'b0);
    chk("a_window_start", RW'(bus.mult_a_o), RW'(win(0)));
    bus.req_i       = 1'b1;
    bus.a_i         = ~pack(aw);
    bus.p_prime_0_i = 17'h1FFFF;
    for (int i = 0; i < 13; i++) begin
      bus.a_shift_i = vt[i].ash;
      bus.b_fetch_i = vt[i].bf;
      bus.p_fetch_i = vt[i].pf;
      @(negedge clk);
      bus.a_shift_i = 1'b0;
      bus.b_fetch_i = 1'b0;
      bus.p_fetch_i = 1'b0;
      chk($sformatf("a_window_v%0d", i), RW'(bus.mult_a_o), RW'(win(vt[i].k)));
      chkw($sformatf("b_word_v%0d", i), bus.mult_b_o, vt[i].b);
      chkw($sformatf("p_word_v%0d", i), bus.mult_p_o, vt[i].p);
      chk1($sformatf("no_ack_busy_v%0d", i), bus.ack_o, 1'b0);
    end
    bus.req_i = 1'b0;
    chkw("p_prime_0_kept", bus.p_prime_0_o, 17'h01234);
    e = pack(rw);
    e[7*WORD_W +: WORD_W] = '0;
    exp_q.push_back(e);
    for (int i = 0; i < S - 1; i++) push(rw[i], 1'b0);
    bus.mult_done_i = 1'b1;
    @(negedge clk);
    bus.mult_done_i = 1'b0;
    collect(1'b1);
    chk1("err_sticky_idle", bus.err_o, 1'b1);

    // Job 3: ninth push overflows and is dropped.
    for (int i = 0; i < S; i++) rw[i] = 17'(i * 17'h0F0F + 17'h3);
    start_job(17'h00777);
    exp_q.push_back(pack(rw));
    for (int i = 0; i < S; i++) push(rw[i], 1'b0);
    chk1("err_after_full", bus.err_o, 1'b0);
    push(17'h1FFFF, 1'b1);
    chk1("err_overflow", bus.err_o, 1'b1);
    collect(1'b1);

    // Job 4: multiplier stalls after two pushes; watchdog forces HOLD.
    start_job(17'h00055);
    e = '0;
    e[0*WORD_W +: WORD_W] = 17'h0AAAA;
    e[1*WORD_W +: WORD_W] = 17'h15555;
    exp_q.push_back(e);
    cnt = 0;
    while (!bus.res_valid_o && cnt < 200) begin
      bus.res_push_i = (cnt < 2);
      bus.res_i      = (cnt == 0) ? 17'h0AAAA : 17'h15555;
      @(negedge clk);
      cnt++;
    end
    bus.res_push_i = 1'b0;
    chk("timeout_run_cycles", RW'(cnt), RW'(TO));
    collect(1'b1);

    // Job 5: reset mid-run with req held high.
    start_job(17'h00042);
    push(17'h12345, 1'b0);
    bus.req_i = 1'b1;
    rst_n     = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("ack_after_release", bus.ack_o, 1'b1);
    @(negedge clk);
    bus.req_i = 1'b0;
    chk1("start_after_release", bus.mult_start_o, 1'b1);
    chk1("busy_after_release", bus.busy_o, 1'b1);
    @(negedge clk);
    for (int i = 0; i < S; i++) rw[i] = 17'(17'h0C000 + i);
    exp_q.push_back(pack(rw));
    for (int i = 0; i < S; i++) push(rw[i], (i == S - 1));
    collect(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
